pwm_multichannel: RTL and testbench

Parametrised multi-channel PWM generator, successor to the single-channel 4-bit `pwm` block. It drives `CHANNELS` outputs from one shared period counter with a programmable clock prescaler. Duty values are double-buffered so updates land only on period boundaries. It sits between the register/control logic and the board-level outputs (LEDs, motor drivers).

---
 rtl/pwm_multichannel.sv | 154 +++++++++++++++
 tb/tb_pwm_multichannel.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel.sv
// ---------------------------------------------------------------------------
// PwmMultichannel (module pwm_multichannel)
//
// Multi-channel PWM generator. One shared period counter, advanced by a
// programmable prescaler, is compared against a per-channel active duty.
// Duty values are double-buffered: `load` writes the shadow register, and the
// shadow moves into the active register only on a period boundary. This keeps
// a channel from glitching when its duty changes mid-period.
//
// Optional feature macro: PWM_CENTER_ALIGNED_EN
//   undefined -> edge-aligned sawtooth, period M ticks (M = 2^WIDTH-1)
//   defined   -> centre-aligned triangle, period 2M ticks
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   enable      run control; low holds the counters at zero and forces outputs low
//   prescale    divisor P; one counter tick every P+1 clocks
//   rate        packed duties, channel i at rate[i*WIDTH +: WIDTH]
//   load        one-cycle strobe capturing rate into the shadow register
//   salida      registered PWM outputs, one per channel
//   period_end  one-clock pulse in the clock where the active duty updates
// ---------------------------------------------------------------------------
module pwm_multichannel #(
   parameter int WIDTH          = 4,
   parameter int CHANNELS       = 4,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [PRESCALE_WIDTH-1:0]   prescale,
   input  logic [CHANNELS*WIDTH-1:0]   rate,
   input  logic                        load,
   output logic [CHANNELS-1:0]         salida,
   output logic                        period_end
);

   // Last counter value of the up ramp is M-1 = all ones except the LSB.
   localparam logic [WIDTH-1:0]          CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
   localparam logic [WIDTH-1:0]          CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE  = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

   logic [PRESCALE_WIDTH-1:0] preCnt;
   logic [WIDTH-1:0]          cnt;
   logic [CHANNELS*WIDTH-1:0] shadowDuty;
   logic [CHANNELS*WIDTH-1:0] activeDuty;
   logic [CHANNELS-1:0]       nextSalida;
   logic                      tick;
   logic                      boundary;

   // The prescaler only produces ticks while running. The compare is an
   // equality against the live divisor, so a counter left above a newly
   // lowered P just keeps counting, rolls over through all-ones and meets P
   // from below; no extra tick is produced on the way.
   assign tick = enable && (preCnt == prescale);

   // Prescaler counter: cleared while stopped and after every tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         preCnt <= '0;
      end else if (!enable || tick) begin
         preCnt <= '0;
      end else begin
         preCnt <= preCnt + PRE_ONE;
      end
   end

`ifdef PWM_CENTER_ALIGNED_EN
   logic countDown;

   // The period ends where the down ramp, sitting at zero, turns back up.
   assign boundary = tick && countDown && (cnt == '0);

   // Triangle counter. At each end the counter value is kept for one extra
   // tick while only the direction flips, so both endpoints last two ticks
   // and the full period is 2M ticks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         countDown <= 1'b0;
      end else if (!enable) begin
         cnt       <= '0;
         countDown <= 1'b0;
      end else if (tick) begin
         if (!countDown) begin
            if (cnt == CNT_LAST) begin
               countDown <= 1'b1;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
         end else begin
            if (cnt == '0) begin
               countDown <= 1'b0;
            end else begin
               cnt <= cnt - CNT_ONE;
            end
         end
      end
   end
`else
   // The period ends on the tick that wraps the sawtooth back to zero.
   assign boundary = tick && (cnt == CNT_LAST);

   // Sawtooth counter 0..M-1, held at zero while stopped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (!enable) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;
      end
   end
`endif

   // Double-buffered duty. A load that lands exactly on a boundary goes
   // straight to the active register, otherwise that write would sit in the
   // shadow for a whole extra period. Loads are taken even while stopped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadowDuty <= '0;
         activeDuty <= '0;
      end else begin
         if (boundary) begin
            activeDuty <= load ? rate : shadowDuty;
         end
         if (load) begin
            shadowDuty <= rate;
         end
      end
   end

   // Per-channel compare. Since cnt never exceeds M-1, a duty of all ones
   // stays high for the whole period and a duty of zero never goes high.
   always_comb begin
      nextSalida = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         nextSalida[i] = enable && (cnt < activeDuty[i*WIDTH +: WIDTH]);
      end
   end

   // Registered outputs; period_end lines up with the active-duty update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         salida     <= '0;
         period_end <= 1'b0;
      end else begin
         salida     <= nextSalida;
         period_end <= boundary;
      end
   end

endmodule

// File: tb/tb_pwm_multichannel.sv
// ---------------------------------------------------------------------------
// Testbench for pwm_multichannel. A behavioural model tracks the position
// inside the period as a plain phase index (0 .. ticks-per-period-1) and
// derives the counter value from it arithmetically; outputs are compared
// every clock. Directed sections measure whole-period high counts and period
// lengths against values computed from the duty/prescale arithmetic, and a
// randomized section drives enable, load, rate, prescale and async reset.
// ---------------------------------------------------------------------------
module tb_pwm_multichannel;

   localparam int WIDTH          = 4;
   localparam int CHANNELS       = 4;
   localparam int PRESCALE_WIDTH = 8;
   localparam int RW             = CHANNELS * WIDTH;
   localparam int M              = (1 << WIDTH) - 1;
`ifdef PWM_CENTER_ALIGNED_EN
   localparam int PER_TICKS      = 2 * M;
`else
   localparam int PER_TICKS      = M;
`endif
   localparam int SHAPE          = PER_TICKS / M;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      enable;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic [RW-1:0]             rate;
   logic                      load;
   logic [CHANNELS-1:0]       salida;
   logic                      period_end;

   int checks = 0;
   int errors = 0;

   int                  mDiv;
   int                  mPhase;
   int                  mShadow [CHANNELS];
   int                  mActive [CHANNELS];
   logic [CHANNELS-1:0] expSalida;
   logic                expPe;

   int hiCount [CHANNELS];
   int peCount;

   pwm_multichannel #(
      .WIDTH(WIDTH),
      .CHANNELS(CHANNELS),
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .prescale(prescale),
      .rate(rate),
      .load(load),
      .salida(salida),
      .period_end(period_end)
   );

   // 10 time-unit clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Counter value seen at a given phase of the period.
   function automatic int cntOfPhase(input int ph);
`ifdef PWM_CENTER_ALIGNED_EN
      return (ph < M) ? ph : (2 * M - 1 - ph);
`else
      return ph;
`endif
   endfunction

   function automatic int rateOf(input logic [RW-1:0] r, input int ch);
      return int'(r[ch*WIDTH +: WIDTH]);
   endfunction

   task automatic modelReset();
      mDiv   = 0;
      mPhase = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         mShadow[i] = 0;
         mActive[i] = 0;
      end
      expSalida = '0;
      expPe     = 1'b0;
   endtask

   // Advance one clock: update the model from the inputs present at the
   // edge, then sample the DUT 1 time unit later.
   task automatic stepClock();
      int  c;
      bit  tk;
      bit  bnd;
      @(posedge clk);
      if (!enable) begin
         mDiv      = 0;
         mPhase    = 0;
         expSalida = '0;
         expPe     = 1'b0;
      end else begin
         c = cntOfPhase(mPhase);
         for (int i = 0; i < CHANNELS; i++) expSalida[i] = (c < mActive[i]);
         tk   = (mDiv == int'(prescale));
         mDiv = tk ? 0 : (mDiv + 1) % (1 << PRESCALE_WIDTH);
         bnd  = tk && (mPhase == PER_TICKS - 1);
         if (tk) mPhase = (mPhase + 1) % PER_TICKS;
         expPe = bnd;
         if (bnd) begin
            for (int i = 0; i < CHANNELS; i++) mActive[i] = load ? rateOf(rate, i) : mShadow[i];
         end
      end
      if (load) begin
         for (int i = 0; i < CHANNELS; i++) mShadow[i] = rateOf(rate, i);
      end
      #1;
      checkOutput("salida", 32'(salida), 32'(expSalida));
      checkOutput("periodEnd", 32'(period_end), 32'(expPe));
   endtask

   // Drive one clock of stimulus; load is a single-cycle strobe.
   task automatic applyStimulus(input logic en, input int p, input logic ld, input logic [RW-1:0] rt);
      enable   = en;
      prescale = PRESCALE_WIDTH'(p);
      load     = ld;
      rate     = rt;
      stepClock();
      load     = 1'b0;
   endtask

   // Async reset asserted between edges; outputs must clear without a clock.
   task automatic applyReset();
      #2 reset = 1'b1;
      #1;
      modelReset();
      checkOutput("rstSalida", 32'(salida), 32'd0);
      checkOutput("rstPeriodEnd", 32'(period_end), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic waitPeriodEnd(input string tag, output int clocks);
      logic seen;
      seen   = 1'b0;
      clocks = 0;
      while (!seen && clocks < 1000) begin
         stepClock();
         clocks++;
         seen = (period_end === 1'b1);
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   task automatic measure(input int n);
      peCount = 0;
      for (int i = 0; i < CHANNELS; i++) hiCount[i] = 0;
      for (int k = 0; k < n; k++) begin
         stepClock();
         peCount += int'(period_end);
         for (int i = 0; i < CHANNELS; i++) hiCount[i] += int'(salida[i]);
      end
   endtask

   // One full period right after a boundary: per-channel high clocks are
   // duty * (P+1) * (ticks per period / M), and exactly one period_end.
   task automatic checkPeriod(input string tag, input int p, input int d0, input int d1, input int d2, input int d3);
      int exp [CHANNELS];
      exp[0] = d0; exp[1] = d1; exp[2] = d2; exp[3] = d3;
      measure((p + 1) * PER_TICKS);
      for (int i = 0; i < CHANNELS; i++)
         checkOutput($sformatf("%s_high%0d", tag, i), 32'(hiCount[i]), 32'(exp[i] * (p + 1) * SHAPE));
      checkOutput($sformatf("%s_peCount", tag), 32'(peCount), 32'd1);
   endtask

   initial begin
      int clocks;

      // Reset with enable high: outputs zero before any clock edge.
      reset    = 1'b1;
      enable   = 1'b1;
      load     = 1'b0;
      prescale = '0;
      rate     = '0;
      modelReset();
      #3;
      checkOutput("resetSalida", 32'(salida), 32'd0);
      checkOutput("resetPeriodEnd", 32'(period_end), 32'd0);
      #9 reset = 1'b0;
      for (int k = 0; k < 20; k++) applyStimulus(1'b1, 0, 1'b0, '0);

      // Duty levels {0,5,15,2} on channels 0..3 at P=0.
      applyStimulus(1'b1, 0, 1'b1, {4'd2, 4'd15, 4'd5, 4'd0});
      waitPeriodEnd("dutyWait", clocks);
      checkPeriod("duty", 0, 0, 5, 15, 2);

      // Double buffer: 5 active, load 10 at cnt=7, new duty only next period.
      applyStimulus(1'b1, 0, 1'b1, {4{4'd5}});
      waitPeriodEnd("dbWait", clocks);
      checkPeriod("db5", 0, 5, 5, 5, 5);
      for (int k = 0; k < 6; k++) applyStimulus(1'b1, 0, 1'b0, '0);
      applyStimulus(1'b1, 0, 1'b1, {4{4'd10}});
      waitPeriodEnd("db10Wait", clocks);
      checkPeriod("db10", 0, 10, 10, 10, 10);

      // Load on the boundary tick itself bypasses the shadow.
      for (int k = 0; k < PER_TICKS - 1; k++) applyStimulus(1'b1, 0, 1'b0, '0);
      applyStimulus(1'b1, 0, 1'b1, {4'd1, 4'd14, 4'd0, 4'd7});
      checkOutput("bypassPe", 32'(period_end), 32'd1);
      checkPeriod("bypass", 0, 7, 0, 14, 1);

      // Prescaler P=3, then drop to 0 mid-run.
      applyStimulus(1'b1, 3, 1'b1, {4{4'd4}});
      waitPeriodEnd("pre3Wait", clocks);
      checkPeriod("pre3", 3, 4, 4, 4, 4);
      for (int k = 0; k < 2 * 4 + 2; k++) applyStimulus(1'b1, 3, 1'b0, '0);
      applyStimulus(1'b1, 0, 1'b0, '0);
      waitPeriodEnd("pre0Wait", clocks);
      checkPeriod("pre0", 0, 4, 4, 4, 4);

      // Enable drop at cnt=9, then restart with P=2.
      applyStimulus(1'b1, 0, 1'b1, {4{4'd12}});
      waitPeriodEnd("enWait", clocks);
      for (int k = 0; k < 9; k++) applyStimulus(1'b1, 0, 1'b0, '0);
      applyStimulus(1'b0, 0, 1'b0, '0);
      checkOutput("enOffSalida", 32'(salida), 32'd0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 2, 1'b0, '0);
      enable = 1'b1;
      waitPeriodEnd("reEnWait", clocks);
      checkOutput("reEnPeriodClocks", 32'(clocks), 32'(3 * PER_TICKS));

      // Reset mid-period with a pending shadow value: it must be lost.
      applyStimulus(1'b1, 0, 1'b1, {4{4'd3}});
      waitPeriodEnd("rstWait", clocks);
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 0, 1'b0, '0);
      applyStimulus(1'b1, 0, 1'b1, {4{4'd12}});
      applyStimulus(1'b1, 0, 1'b0, '0);
      applyReset();
      waitPeriodEnd("postRstWait", clocks);
      checkPeriod("postRst", 0, 0, 0, 0, 0);

      // Randomized run checked against the model every clock.
      prescale = '0;
      for (int k = 0; k < 3000; k++) begin
         enable = ($urandom_range(0, 31) != 0);
         load   = ($urandom_range(0, 7) == 0);
         rate   = RW'($urandom);
         if ($urandom_range(0, 63) == 0) prescale = PRESCALE_WIDTH'($urandom_range(0, 3));
         stepClock();
         load = 1'b0;
         if ($urandom_range(0, 499) == 0) applyReset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
